// File: rtl/f7_stream_accumulator.sv
// ---------------------------------------------------------------------------
// f7_stream_accumulator: expands 7-bit floats and sums N_SAMPLES per frame
// with saturation, then presents one frame result per handshake.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module f7_stream_accumulator #(
  parameter int N_SAMPLES = 8,
  parameter int SUM_W     = 14,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_float,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat
);

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t             state;
  logic [SUM_W-1:0]   acc_sum;
  logic [CNT_W-1:0]   acc_cnt;
  logic               acc_sat;

  logic [10:0]        value;
  logic [SUM_W:0]     sum_wide;
  logic [SUM_W-1:0]   sum_add;
  logic               sat_add;
  logic [CNT_W-1:0]   cnt_add;
  logic               accept;
  logic               last;
  logic               close;

  // e==0 is the denormal range; otherwise the implicit leading one is restored.
  always_comb begin
    value = 11'd0;
    if (in_float[6:4] == 3'd0) begin
      value = {7'd0, in_float[3:0]};
    end else begin
      value = {6'd0, 1'b1, in_float[3:0]} << (in_float[6:4] - 3'd1);
    end
  end

  assign in_ready = (state == ACC) && !rst;
  assign accept   = in_valid && in_ready;

  assign sum_wide = {1'b0, acc_sum} + {{(SUM_W-10){1'b0}}, value};
  assign sum_add  = sum_wide[SUM_W] ? {SUM_W{1'b1}} : sum_wide[SUM_W-1:0];
  assign sat_add  = acc_sat | sum_wide[SUM_W];
  assign cnt_add  = acc_cnt + CNT_W'(1);

  assign last  = accept && (cnt_add == CNT_W'(N_SAMPLES));
  // A flush only closes a frame that holds at least one sample.
  assign close = (state == ACC) &&
                 (last || (flush && (accept || (acc_cnt != '0))));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACC;
      acc_sum   <= '0;
      acc_cnt   <= '0;
      acc_sat   <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            acc_sum <= sum_add;
            acc_cnt <= cnt_add;
            acc_sat <= sat_add;
          end
          if (close) begin
            out_sum   <= accept ? sum_add : acc_sum;
            out_count <= accept ? cnt_add : acc_cnt;
            out_sat   <= accept ? sat_add : acc_sat;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc_sum   <= '0;
            acc_cnt   <= '0;
            acc_sat   <= 1'b0;
            state     <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_f7_stream_accumulator.sv
// ---------------------------------------------------------------------------
// tb_f7_stream_accumulator: scoreboard bench driving two accumulator widths
// with identical streams.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_f7_stream_accumulator;

  localparam int N  = 8;
  localparam int WA = 14;
  localparam int WB = 12;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [6:0]    in_float;
  logic          flush;
  logic          out_ready;

  logic          in_ready_a, in_ready_b;
  logic          out_valid_a, out_valid_b;
  logic [WA-1:0] out_sum_a;
  logic [WB-1:0] out_sum_b;
  logic [CW-1:0] out_count_a, out_count_b;
  logic          out_sat_a, out_sat_b;

  f7_stream_accumulator #(.N_SAMPLES(N), .SUM_W(WA), .CNT_W(CW)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_float(in_float), .flush(flush), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_sum(out_sum_a), .out_count(out_count_a),
    .out_sat(out_sat_a)
  );

  f7_stream_accumulator #(.N_SAMPLES(N), .SUM_W(WB), .CNT_W(CW)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_float(in_float), .flush(flush), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_sum(out_sum_b), .out_count(out_count_b),
    .out_sat(out_sat_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sum;
    int cnt;
    bit sat;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  // Reference model state: a frame is just a running total and a sample count.
  bit   m_hold  = 1'b0;
  int   m_total = 0;
  int   m_cnt   = 0;

  function automatic int decode(input logic [6:0] f);
    int e;
    int m;
    e = int'(f[6:4]);
    m = int'(f[3:0]);
    return (e == 0) ? m : ((16 + m) << (e - 1));
  endfunction

  function automatic exp_t mk(input int total, input int cnt, input int w);
    exp_t x;
    int   mx;
    mx    = (1 << w) - 1;
    x.sat = (total > mx);
    x.sum = x.sat ? mx : total;
    x.cnt = cnt;
    return x;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_hold  = 1'b0;
      m_total = 0;
      m_cnt   = 0;
      qa.delete();
      qb.delete();
    end else if (m_hold) begin
      if (out_ready) begin
        m_hold  = 1'b0;
        m_total = 0;
        m_cnt   = 0;
      end
    end else begin
      if (in_valid) begin
        m_total += decode(in_float);
        m_cnt++;
      end
      if ((in_valid && m_cnt == N) || (flush && m_cnt > 0)) begin
        qa.push_back(mk(m_total, m_cnt, WA));
        qb.push_back(mk(m_total, m_cnt, WB));
        m_hold = 1'b1;
      end
    end
  endtask

  // Inputs are applied 2 time units after a rising edge and held for one cycle.
  task automatic tick(input logic v, input logic [6:0] f, input logic fl,
                      input logic ordy, input logic r);
    in_valid  = v;
    in_float  = f;
    flush     = fl;
    out_ready = ordy;
    rst       = r;
    @(posedge clk);
    model_update();
    #2;
  endtask

  task automatic samples(input int n, input logic [6:0] f, input logic ordy);
    for (int i = 0; i < n; i++) tick(1'b1, f, 1'b0, ordy, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 7'($urandom_range(0, 127)), 1'b0, 1'b1, 1'b0);
  endtask

  // Monitor: compares handshake signals every cycle and pops on each result transfer.
  logic          prev_stall = 1'b0;
  logic [WA-1:0] prev_sum_a;
  logic [CW-1:0] prev_cnt_a;
  logic          prev_sat_a;

  always @(negedge clk) begin
    if (mon_en) begin
      check("in_ready_a", int'(in_ready_a), int'(!m_hold && !rst));
      check("in_ready_b", int'(in_ready_b), int'(!m_hold && !rst));
      check("out_valid_a", int'(out_valid_a), int'(m_hold));
      check("out_valid_b", int'(out_valid_b), int'(m_hold));
      if (prev_stall && out_valid_a) begin
        check("stall_sum_a", int'(out_sum_a), int'(prev_sum_a));
        check("stall_cnt_a", int'(out_count_a), int'(prev_cnt_a));
        check("stall_sat_a", int'(out_sat_a), int'(prev_sat_a));
      end
      if (out_valid_a && out_ready && !rst) begin
        if (qa.size() == 0) begin
          check("unexpected_frame_a", 1, 0);
        end else begin
          exp_t e;
          e = qa.pop_front();
          check("sum_a", int'(out_sum_a), e.sum);
          check("count_a", int'(out_count_a), e.cnt);
          check("sat_a", int'(out_sat_a), int'(e.sat));
        end
      end
      if (out_valid_b && out_ready && !rst) begin
        if (qb.size() == 0) begin
          check("unexpected_frame_b", 1, 0);
        end else begin
          exp_t e;
          e = qb.pop_front();
          check("sum_b", int'(out_sum_b), e.sum);
          check("count_b", int'(out_count_b), e.cnt);
          check("sat_b", int'(out_sat_b), int'(e.sat));
        end
      end
      prev_stall = out_valid_a && !out_ready && !rst;
      prev_sum_a = out_sum_a;
      prev_cnt_a = out_count_a;
      prev_sat_a = out_sat_a;
    end
  end

  logic [6:0] sweep [6];

  initial begin
    sweep[0] = 7'h05; sweep[1] = 7'h10; sweep[2] = 7'h20;
    sweep[3] = 7'h4A; sweep[4] = 7'h7F; sweep[5] = 7'h00;

    tick(1'b1, 7'h7F, 1'b1, 1'b0, 1'b1);
    tick(1'b0, 7'h00, 1'b0, 1'b0, 1'b1);
    check("rst_out_valid_a", int'(out_valid_a), 0);
    check("rst_out_sum_a", int'(out_sum_a), 0);
    check("rst_out_count_b", int'(out_count_b), 0);
    check("rst_out_sat_b", int'(out_sat_b), 0);
    mon_en = 1'b1;

    // Basic frame of eight 31s.
    samples(8, 7'h1F, 1'b1);
    idle(3);

    // Decode sweep: each single sample is closed by a same-cycle flush.
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, sweep[i], 1'b1, 1'b1, 1'b0);
      idle(2);
    end

    // Full-scale frame saturates only the narrow instance; zeros clear sat.
    samples(8, 7'h7F, 1'b1);
    idle(3);
    samples(8, 7'h00, 1'b1);
    idle(3);

    // Flush behaviours: partial frame, empty flush, flush with the last sample.
    samples(3, 7'h10, 1'b1);
    tick(1'b0, 7'h00, 1'b1, 1'b1, 1'b0);
    idle(3);
    tick(1'b0, 7'h00, 1'b1, 1'b1, 1'b0);
    idle(2);
    samples(7, 7'h21, 1'b1);
    tick(1'b1, 7'h33, 1'b1, 1'b1, 1'b0);
    idle(3);

    // Backpressure with in_valid held high through the stall.
    samples(8, 7'h2C, 1'b0);
    samples(5, 7'h7F, 1'b0);
    samples(9, 7'h1F, 1'b1);
    idle(3);

    // Reset mid-frame and during HOLD.
    samples(5, 7'h55, 1'b1);
    tick(1'b0, 7'h00, 1'b0, 1'b1, 1'b1);
    samples(8, 7'h1F, 1'b1);
    idle(3);
    samples(8, 7'h66, 1'b0);
    idle(0);
    tick(1'b0, 7'h00, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 7'h00, 1'b0, 1'b0, 1'b1);
    samples(8, 7'h1F, 1'b1);
    idle(3);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 9) < 7),
           7'($urandom_range(0, 127)),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 149) == 0));
    end

    for (int i = 0; i < 20 && (m_hold || qa.size() > 0 || qb.size() > 0); i++) idle(1);
    check("drain_a", qa.size(), 0);
    check("drain_b", qb.size(), 0);
    check("drain_hold", int'(m_hold), 0);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
